// File: rtl/sensor_stream_frontend.sv
// Streaming sensor front end: drop-on-full sample FIFO, then a saturating offset and
// a hysteresis threshold decision presented on a valid/ready output register.
module sensor_stream_frontend #(
  parameter int                DATA_W = 16,
  parameter int                DEPTH  = 8,
  parameter int                CNT_W  = 8,
  parameter logic [DATA_W-1:0] OFFSET = 16'h0010,
  parameter logic [DATA_W-1:0] THR_HI = 16'h0088,
  parameter logic [DATA_W-1:0] THR_LO = 16'h0078
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        sensor_data,
  input  logic                     data_valid,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        processed_data,
  output logic                     decision,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [CNT_W-1:0]         overflow_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     head_q, tail_q;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, empty_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] data_q;
  logic              decision_q, decision_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;

  logic              pop, push, drop;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] sat_value;

  // Pop whenever the output register is empty or being drained; the sensor side
  // can still push into a full FIFO if a pop frees a slot in the same cycle.
  assign pop  = !empty_q && (!out_valid_q || out_ready);
  assign push = data_valid && (!full_q || pop);
  assign drop = data_valid && full_q && !pop;

  assign sum       = {1'b0, mem_q[head_q]} + {1'b0, OFFSET};
  assign sat_value = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];

  always_comb begin
    decision_d = decision_q;
    if (sat_value > THR_HI) begin
      decision_d = 1'b1;
    end else if (sat_value < THR_LO) begin
      decision_d = 1'b0;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop && (ovf_q != {CNT_W{1'b1}})) begin
      ovf_d = ovf_q + 1'b1;
    end
  end

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= sensor_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      decision_q  <= 1'b0;
      ovf_q       <= '0;
    end else begin
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
      ovf_q   <= ovf_d;
      if (push) begin
        tail_q <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q      <= head_q + 1'b1;
        out_valid_q <= 1'b1;
        data_q      <= sat_value;
        decision_q  <= decision_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign processed_data = data_q;
  assign decision       = decision_q;
  assign fifo_level     = level_q;
  assign fifo_full      = full_q;
  assign fifo_empty     = empty_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_sensor_stream_frontend.sv
// Randomised and directed bench for sensor_stream_frontend against a queue-based model.
module tb_sensor_stream_frontend;

  localparam int DEPTH  = 8;
  localparam int OFFSET = 'h10;
  localparam int THR_HI = 'h88;
  localparam int THR_LO = 'h78;
  localparam int CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sensor_data;
  logic        data_valid;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] processed_data;
  logic        decision;
  logic [3:0]  fifo_level;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  overflow_count;

  sensor_stream_frontend dut (
    .clk            (clk),
    .rst            (rst),
    .sensor_data    (sensor_data),
    .data_valid     (data_valid),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .processed_data (processed_data),
    .decision       (decision),
    .fifo_level     (fifo_level),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .overflow_count (overflow_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, expressed in terms of the observable behaviour only.
  int m_fifo[$];
  int m_valid, m_data, m_dec, m_ovf;
  int accepted[$];  // {decision, data} of each output handed downstream

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit dv, input int d, input bit rdy);
    bit pop, push;
    int v;
    if (r) begin
      m_fifo.delete();
      m_valid = 0; m_data = 0; m_dec = 0; m_ovf = 0;
      return;
    end
    pop  = (m_fifo.size() != 0) && (!m_valid || rdy);
    push = dv && ((m_fifo.size() < DEPTH) || pop);
    if (dv && !push && m_ovf < CNT_MAX) m_ovf++;
    if (pop) begin
      v = m_fifo.pop_front() + OFFSET;
      if (v > 'hFFFF) v = 'hFFFF;
      if (v > THR_HI) m_dec = 1;
      else if (v < THR_LO) m_dec = 0;
      m_data  = v;
      m_valid = 1;
    end else if (rdy) begin
      m_valid = 0;
    end
    if (push) m_fifo.push_back(d);
  endtask

  task automatic do_cycle(input bit r, input bit dv, input int d, input bit rdy);
    rst = r; data_valid = dv; sensor_data = 16'(d); out_ready = rdy;
    if (!r && out_valid && out_ready) begin
      accepted.push_back({15'd0, decision, processed_data});
      $display("xfer data=0x%04h decision=%0d", processed_data, decision);
    end
    model_step(r, dv, d, rdy);
    @(posedge clk);
    #1;
    check_eq("out_valid", {31'd0, out_valid}, m_valid);
    check_eq("fifo_level", {28'd0, fifo_level}, m_fifo.size());
    check_eq("fifo_full", {31'd0, fifo_full}, (m_fifo.size() == DEPTH) ? 1 : 0);
    check_eq("fifo_empty", {31'd0, fifo_empty}, (m_fifo.size() == 0) ? 1 : 0);
    check_eq("overflow_count", {24'd0, overflow_count}, m_ovf);
    check_eq("processed_data", {16'd0, processed_data}, m_data);
    check_eq("decision", {31'd0, decision}, m_dec);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && (out_valid || !fifo_empty); i++) do_cycle(0, 0, 0, 1);
    check_eq("drain_timeout", {31'd0, out_valid | ~fifo_empty}, 0);
  endtask

  function automatic int rand_sample();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 'hFFFF);
      1: return $urandom_range('h60, 'h90);
      2: return $urandom_range('hFFE0, 'hFFFF);
      default: return $urandom_range(0, 'h100);
    endcase
  endfunction

  initial begin
    int exp_h[4];
    rst = 1'b1; data_valid = 1'b0; sensor_data = '0; out_ready = 1'b0;

    // Reset held two cycles with samples arriving
    do_cycle(1, 1, 'h1234, 1);
    do_cycle(1, 1, 'h5678, 0);
    check_eq("rst_empty", {31'd0, fifo_empty}, 1);
    check_eq("rst_valid", {31'd0, out_valid}, 0);

    // Latency: one sample, output exactly two edges later, single-cycle pulse
    do_cycle(0, 1, 'h0050, 1);
    check_eq("lat_edge1_valid", {31'd0, out_valid}, 0);
    do_cycle(0, 0, 0, 1);
    check_eq("lat_edge2_valid", {31'd0, out_valid}, 1);
    check_eq("lat_data", {16'd0, processed_data}, 'h0060);
    check_eq("lat_dec", {31'd0, decision}, 0);
    do_cycle(0, 0, 0, 1);
    check_eq("lat_pulse_end", {31'd0, out_valid}, 0);

    // Hysteresis sequence
    accepted.delete();
    do_cycle(0, 1, 'h0080, 1);
    do_cycle(0, 1, 'h0070, 1);
    do_cycle(0, 1, 'h0060, 1);
    do_cycle(0, 1, 'h0075, 1);
    drain(20);
    exp_h = '{'h10090, 'h10080, 'h00070, 'h00085};
    check_eq("hyst_count", accepted.size(), 4);
    for (int i = 0; i < 4 && i < accepted.size(); i++) check_eq("hyst_out", accepted[i], exp_h[i]);

    // Saturation at the top of the range
    accepted.delete();
    do_cycle(0, 1, 'hFFF8, 1);
    do_cycle(0, 1, 'hFFEF, 1);
    drain(20);
    check_eq("sat_count", accepted.size(), 2);
    for (int i = 0; i < 2 && i < accepted.size(); i++) check_eq("sat_out", accepted[i], 'h1FFFF);

    // Backpressure and overflow: samples 1..10 with the output stalled
    accepted.delete();
    for (int s = 1; s <= 10; s++) do_cycle(0, 1, s, 0);
    check_eq("bp_hold_data", {16'd0, processed_data}, 'h0011);
    check_eq("bp_full", {31'd0, fifo_full}, 1);
    check_eq("bp_ovf", {24'd0, overflow_count}, 1);
    drain(20);
    check_eq("bp_count", accepted.size(), 9);
    for (int i = 0; i < 9 && i < accepted.size(); i++)
      check_eq("bp_order", accepted[i] & 'hFFFF, 'h11 + i);

    // Full FIFO with simultaneous push and pop, then a mid-stream reset
    for (int s = 0; s < 10; s++) do_cycle(0, 1, 'h200 + s, 0);
    do_cycle(0, 1, 'h300, 1);
    check_eq("full_pp_level", {28'd0, fifo_level}, 8);
    check_eq("full_pp_ovf", {24'd0, overflow_count}, 2);
    do_cycle(1, 1, 'h301, 1);
    check_eq("midrst_valid", {31'd0, out_valid}, 0);
    check_eq("midrst_level", {28'd0, fifo_level}, 0);
    check_eq("midrst_ovf", {24'd0, overflow_count}, 0);

    // Long stall drives the overflow counter into saturation
    for (int i = 0; i < 280; i++) do_cycle(0, 1, rand_sample(), 0);
    check_eq("ovf_saturated", {24'd0, overflow_count}, CNT_MAX);
    drain(20);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      do_cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
               rand_sample(), ($urandom_range(0, 2) != 0));
    end
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
